// File: rtl/aucohl_fifo_wr_arbiter_pkg.sv
// Shared FSM encoding and index helpers for the aucohl FIFO write arbiter.
package aucohl_fifo_wr_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_LOCK = 2'd2
  } arb_state_t;

  // Smallest w with 2**w >= n; elaboration-time only.
  function automatic int arb_clog2(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < n) w = i + 1;
    end
    return w;
  endfunction

  function automatic int wrap_inc(input int k, input int n);
    return (k + 1 >= n) ? 0 : k + 1;
  endfunction

endpackage

// File: rtl/aucohl_fifo_wr_arbiter_rr_pick.sv
// Rotate-priority finder: first requester at or above ptr, wrapping to 0.
module aucohl_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  sel,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Two passes: indices from ptr upward win over the wrapped-around ones.
  always_comb begin
    sel = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any && req[k] && (IW'(k) >= ptr)) begin
        any    = 1'b1;
        sel[k] = 1'b1;
        idx    = IW'(k);
      end
    end
    for (int k = 0; k < N; k++) begin
      if (!any && req[k] && (IW'(k) < ptr)) begin
        any    = 1'b1;
        sel[k] = 1'b1;
        idx    = IW'(k);
      end
    end
  end

endmodule

// File: rtl/aucohl_fifo_wr_arbiter.sv
// Round-robin arbiter sharing one aucohl_fifo write port among N sources.
// Optional burst locking is enabled with the AUCOHL_ARB_BURST_EN macro.
module aucohl_fifo_wr_arbiter
  import aucohl_fifo_wr_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int IW    = 2,
  parameter int DW    = 8,
  parameter int BURST = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [N-1:0]    req,
  input  logic [N*DW-1:0] data,
  output logic [N-1:0]    gnt,
  input  logic            fifo_full,
  output logic            fifo_wr,
  output logic [DW-1:0]   fifo_wdata,
  output logic [IW-1:0]   owner,
  output logic            busy
);

  arb_state_t    state, state_nx;
  logic [IW-1:0] rr_ptr, rr_ptr_nx;
  logic [IW-1:0] owner_nx;
  logic [N-1:0]  pick_sel;
  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic [DW-1:0] wdata;

`ifdef AUCOHL_ARB_BURST_EN
  localparam int CW = arb_clog2(BURST + 1);
  logic [CW-1:0] cnt, cnt_nx;
`endif

  aucohl_rr_pick #(.N(N), .IW(IW)) u_pick (
    .req (req),
    .ptr (rr_ptr),
    .sel (pick_sel),
    .idx (pick_idx),
    .any (pick_any)
  );

  // State, pointer, owner and burst count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      rr_ptr <= '0;
      owner  <= '0;
`ifdef AUCOHL_ARB_BURST_EN
      cnt    <= '0;
`endif
    end else begin
      state  <= state_nx;
      rr_ptr <= rr_ptr_nx;
      owner  <= owner_nx;
`ifdef AUCOHL_ARB_BURST_EN
      cnt    <= cnt_nx;
`endif
    end
  end

  // Zero-latency grant and next-state decision; a full FIFO freezes everything.
  always_comb begin
    state_nx  = state;
    rr_ptr_nx = rr_ptr;
    owner_nx  = owner;
    gnt       = '0;
`ifdef AUCOHL_ARB_BURST_EN
    cnt_nx    = cnt;
`endif
    case (state)
      ST_IDLE: begin
        if (en) state_nx = ST_ARB;
        else    state_nx = ST_IDLE;
      end
      ST_ARB: begin
        if (!en) begin
          state_nx = ST_IDLE;
        end else if (!fifo_full && pick_any) begin
          gnt       = pick_sel;
          owner_nx  = pick_idx;
          rr_ptr_nx = IW'(wrap_inc(int'(pick_idx), N));
`ifdef AUCOHL_ARB_BURST_EN
          if (BURST > 1) begin
            state_nx = ST_LOCK;
            cnt_nx   = CW'(1);
          end else begin
            state_nx = ST_ARB;
          end
`endif
        end else begin
          state_nx = ST_ARB;
        end
      end
`ifdef AUCOHL_ARB_BURST_EN
      ST_LOCK: begin
        if (!en) begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end else if (!req[owner]) begin
          // Owner released early: hand the port back without granting.
          state_nx  = ST_ARB;
          cnt_nx    = '0;
          rr_ptr_nx = IW'(wrap_inc(int'(owner), N));
        end else if (!fifo_full) begin
          gnt[owner] = 1'b1;
          rr_ptr_nx  = IW'(wrap_inc(int'(owner), N));
          if (int'(cnt) + 1 >= BURST) begin
            state_nx = ST_ARB;
            cnt_nx   = '0;
          end else begin
            cnt_nx   = cnt + CW'(1);
          end
        end else begin
          state_nx = ST_LOCK;
        end
      end
`endif
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Data mux: OR of the one-hot granted slice, zero when nothing is granted.
  always_comb begin
    wdata = '0;
    for (int k = 0; k < N; k++) begin
      if (gnt[k]) wdata = wdata | data[k*DW +: DW];
    end
  end

  assign fifo_wdata = wdata;
  assign fifo_wr    = |gnt;

`ifdef AUCOHL_ARB_BURST_EN
  assign busy = (state == ST_LOCK);
`else
  assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_aucohl_fifo_wr_arbiter.sv
// Self-checking bench: behavioural arbiter model plus a queue standing in for the FIFO.
module tb_aucohl_fifo_wr_arbiter;
  localparam int N = 4, IW = 2, DW = 8, BURST = 4;
`ifdef AUCOHL_ARB_BURST_EN
  localparam bit BEN = 1'b1;
`else
  localparam bit BEN = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, fifo_full = 1'b0;
  logic [N-1:0] req = '0;
  logic [N*DW-1:0] data = '0;
  logic [N-1:0] gnt;
  logic fifo_wr, busy;
  logic [DW-1:0] fifo_wdata;
  logic [IW-1:0] owner;

  always #5 clk = ~clk;

  aucohl_fifo_wr_arbiter #(.N(N), .IW(IW), .DW(DW), .BURST(BURST)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .data(data), .gnt(gnt),
    .fifo_full(fifo_full), .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata),
    .owner(owner), .busy(busy)
  );

  int total = 0, bad = 0;
  int m_mode = 0, m_ptr = 0, m_owner = 0, m_cnt = 0; // mode: 0 idle, 1 arbitrating, 2 locked
  logic [DW-1:0] fq[$];  // what the DUT wrote
  logic [DW-1:0] eq[$];  // what the model says should have been written
  logic [N-1:0] last_gnt = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_mode = 0; m_ptr = 0; m_owner = 0; m_cnt = 0;
  endtask

  // One clock: check outputs against the model, then advance FIFO and model.
  task automatic step(input bit do_pop);
    logic [N-1:0] eg;
    logic [DW-1:0] ed, wd_s;
    logic wr_s;
    int ei;
    fifo_full = (fq.size() >= 16);
    #1;
    eg = '0; ei = -1; ed = '0;
    if (m_mode == 1 && en && !fifo_full) begin
      for (int i = 0; i < N; i++)
        if (ei < 0 && req[(m_ptr + i) % N]) ei = (m_ptr + i) % N;
    end else if (m_mode == 2 && en && !fifo_full && req[m_owner]) begin
      ei = m_owner;
    end
    if (ei >= 0) begin eg[ei] = 1'b1; ed = data[ei*DW +: DW]; end
    chk("gnt", gnt, eg);
    chk("fifo_wr", fifo_wr, ei >= 0);
    chk("fifo_wdata", fifo_wdata, ed);
    chk("owner", owner, m_owner);
    chk("busy", busy, m_mode == 2);
    last_gnt = gnt; wr_s = fifo_wr; wd_s = fifo_wdata;
    @(posedge clk);
    if (do_pop && fq.size() > 0 && eq.size() > 0) chk("fifo_rd", fq.pop_front(), eq.pop_front());
    if (wr_s) fq.push_back(wd_s);
    if (ei >= 0) eq.push_back(ed);
    if (m_mode == 0) begin
      if (en) m_mode = 1;
    end else if (!en) begin
      m_mode = 0; m_cnt = 0;
    end else if (m_mode == 1) begin
      if (ei >= 0) begin
        m_owner = ei; m_ptr = (ei + 1) % N;
        if (BEN && BURST > 1) begin m_mode = 2; m_cnt = 1; end
      end
    end else if (!req[m_owner]) begin
      m_mode = 1; m_cnt = 0; m_ptr = (m_owner + 1) % N;
    end else if (ei >= 0) begin
      m_cnt++;
      if (m_cnt == BURST) begin m_mode = 1; m_cnt = 0; end
    end
    @(negedge clk);
  endtask

  task automatic async_reset();
    #2; rst_n = 1'b0; #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_owner", owner, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fifo_wr", fifo_wr, 0);
    m_reset();
    @(negedge clk); rst_n = 1'b1;
  endtask

  logic [N-1:0] rr_exp [8];
  logic [DW-1:0] rr_dat [8];

  initial begin
    if (BEN) begin
      rr_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010};
      rr_dat = '{8'hA0, 8'hA0, 8'hA0, 8'hA0, 8'hA1, 8'hA1, 8'hA1, 8'hA1};
    end else begin
      rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
      rr_dat = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0, 8'hA1, 8'hA2, 8'hA3};
    end
    m_reset();
    @(negedge clk); @(negedge clk);
    chk("init_gnt", gnt, 0); chk("init_owner", owner, 0);
    chk("init_busy", busy, 0); chk("init_fifo_wr", fifo_wr, 0);
    rst_n = 1'b1;

    // Round-robin with all sources requesting
    en = 1'b1; req = 4'b1111;
    for (int k = 0; k < N; k++) data[k*DW +: DW] = 8'hA0 + 8'(k);
    step(1'b0);
    chk("rr_idle_cycle", last_gnt, 0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0);
      chk("rr_seq", last_gnt, rr_exp[i]);
    end
    chk("rr_fifo_level", fq.size(), 8);
    for (int i = 0; i < 8 && i < fq.size(); i++) chk("rr_fifo_data", fq[i], rr_dat[i]);
    fq.delete(); eq.delete();

    // Sparse request with wrap from pointer 3 to source 0
    req = 4'b0100; step(1'b0);
    req = 4'b0000; step(1'b0);
    req = 4'b0101; step(1'b0);
    chk("wrap_gnt", last_gnt, 4'b0001);
    chk("wrap_owner0", owner, 0);
    req = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      step(1'b0);
      if (last_gnt != 0) break;
    end
    chk("wrap_gnt2", last_gnt, 4'b0100);
    chk("wrap_owner2", owner, 2);

    // Enable gating retains the pointer
    en = 1'b0; req = 4'b1111;
    for (int i = 0; i < 3; i++) begin step(1'b0); chk("en_off_gnt", last_gnt, 0); end
    en = 1'b1;
    step(1'b0); chk("en_idle_gnt", last_gnt, 0);
    step(1'b0); chk("en_resume_gnt", last_gnt, 4'b1000);

    // Full backpressure with a counting source 0
    fq.delete(); eq.delete();
    req = 4'b0001; data = '0;
    for (int i = 0; i < 40 && fq.size() < 16; i++) begin
      step(1'b0);
      if (last_gnt[0]) data[7:0] = data[7:0] + 8'd1;
    end
    chk("full_level", fq.size(), 16);
    for (int i = 0; i < 3; i++) begin
      step(1'b0);
      chk("full_gnt", last_gnt, 0);
      chk("full_wr", fifo_wr, 0);
    end
    step(1'b1);
    chk("full_pop_gnt", last_gnt, 0);
    step(1'b0);
    chk("after_pop_gnt", last_gnt, 4'b0001);
    for (int i = 0; i < fq.size(); i++) chk("full_seq", fq[i], 8'(i + 1));
    fq.delete(); eq.delete();

    // Reset in the middle of a source-1 stream
    req = 4'b0010;
    for (int i = 0; i < 3; i++) step(1'b0);
    async_reset();
    step(1'b0); chk("post_rst_idle", last_gnt, 0);
    step(1'b0); chk("post_rst_gnt", last_gnt, 4'b0010);
    chk("post_rst_owner", owner, 1);

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < N; k++) begin
        if (last_gnt[k] || !req[k]) begin
          req[k] = ($urandom_range(0, 2) != 0);
          data[k*DW +: DW] = 8'($urandom);
        end
      end
      en = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 799) == 0) async_reset();
      else step($urandom_range(0, 2) == 0);
    end
    while (fq.size() > 0 && eq.size() > 0) chk("drain", fq.pop_front(), eq.pop_front());
    chk("drain_level", fq.size(), eq.size());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
